// File: rtl/imem_loader.sv
// Streams program bytes into 32-bit big-endian words and writes them
// to instruction memory, one word-write strobe per assembled word.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err_overflow,
    output logic [AW:0]   byte_count
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [AW-1:0] LAST_BASE = AW'(DEPTH - 4);

    state_t        state, state_nx;
    logic [AW-1:0] base;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic          last_seen;
    logic          err_q;
    logic [AW:0]   cnt;
    logic          at_end;

    assign at_end       = (base == LAST_BASE);
    assign wr_addr      = base;
    assign wr_data      = (state == WRITE) ? word : 32'h0;
    assign byte_count   = cnt;
    assign err_overflow = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RECV;
            end
            RECV: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && (lane == 2'd3 || in_last))
                    state_nx = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                state_nx = (last_seen || at_end) ? DONE : RECV;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = RECV;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            lane      <= '0;
            word      <= '0;
            last_seen <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base      <= '0;
                        lane      <= '0;
                        word      <= '0;
                        last_seen <= 1'b0;
                        err_q     <= 1'b0;
                        cnt       <= '0;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        // lane 0 lands in [31:24], lane 3 in [7:0]
                        word[{~lane, 3'b000} +: 8] <= in_data;
                        lane      <= lane + 2'd1;
                        cnt       <= cnt + (AW+1)'(1);
                        last_seen <= in_last;
                    end
                end
                WRITE: begin
                    base <= base + AW'(4);
                    lane <= '0;
                    word <= '0;
                    if (!last_seen && at_end) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
